// File: rtl/segre_csr_if.sv
// CSR port bundle between decode/execute/trap logic and the machine-mode CSR unit.
// Latency: carries no state; it only groups the wires.
// Backpressure: none; every request is consumed in the cycle it is presented.
interface segre_csr_if #(
    parameter int WORD_SIZE  = 32,
    parameter int CSR_ADDR_W = 12
);
    logic [CSR_ADDR_W-1:0] csr_addr_i;
    logic [1:0]            csr_op_i;
    logic [WORD_SIZE-1:0]  csr_wdata_i;
    logic [WORD_SIZE-1:0]  csr_rdata_o;
    logic                  csr_illegal_o;
    logic                  retire_i;
    logic                  exc_i;
    logic [WORD_SIZE-1:0]  exc_cause_i;
    logic [WORD_SIZE-1:0]  exc_pc_i;
    logic [WORD_SIZE-1:0]  exc_tval_i;
    logic                  mret_i;
    logic [WORD_SIZE-1:0]  mtvec_o;
    logic [WORD_SIZE-1:0]  mepc_o;
    logic                  mie_global_o;

    // Pipeline side: drives requests and strobes, observes CSR results.
    modport master (
        output csr_addr_i, csr_op_i, csr_wdata_i, retire_i,
        output exc_i, exc_cause_i, exc_pc_i, exc_tval_i, mret_i,
        input  csr_rdata_o, csr_illegal_o, mtvec_o, mepc_o, mie_global_o
    );

    // CSR unit side.
    modport slave (
        input  csr_addr_i, csr_op_i, csr_wdata_i, retire_i,
        input  exc_i, exc_cause_i, exc_pc_i, exc_tval_i, mret_i,
        output csr_rdata_o, csr_illegal_o, mtvec_o, mepc_o, mie_global_o
    );
endinterface

// File: rtl/segre_csr_unit.sv
// Machine-mode CSR file with RW/RS/RC ops, 64-bit cycle/instret counters and trap/mret status stacking.
// Latency: reads and illegal flag are combinational; writes, trap and mret effects land on the next edge.
// Backpressure: none; an op is accepted every cycle, exc/mret take priority and drop a colliding write.
module segre_csr_unit #(
    parameter int                   WORD_SIZE    = 32,
    parameter int                   CSR_ADDR_W   = 12,
    parameter logic [WORD_SIZE-1:0] MTVEC_RESET  = '0,
    parameter bit                   HAS_COUNTERS = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    segre_csr_if.slave   bus
);

    localparam int CNT_W = 2 * WORD_SIZE;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    localparam logic [CSR_ADDR_W-1:0] ADDR_MSTATUS   = CSR_ADDR_W'('h300);
    localparam logic [CSR_ADDR_W-1:0] ADDR_MIE       = CSR_ADDR_W'('h304);
    localparam logic [CSR_ADDR_W-1:0] ADDR_MTVEC     = CSR_ADDR_W'('h305);
    localparam logic [CSR_ADDR_W-1:0] ADDR_MSCRATCH  = CSR_ADDR_W'('h340);
    localparam logic [CSR_ADDR_W-1:0] ADDR_MEPC      = CSR_ADDR_W'('h341);
    localparam logic [CSR_ADDR_W-1:0] ADDR_MCAUSE    = CSR_ADDR_W'('h342);
    localparam logic [CSR_ADDR_W-1:0] ADDR_MTVAL     = CSR_ADDR_W'('h343);
    localparam logic [CSR_ADDR_W-1:0] ADDR_MCYCLE    = CSR_ADDR_W'('hB00);
    localparam logic [CSR_ADDR_W-1:0] ADDR_MCYCLEH   = CSR_ADDR_W'('hB80);
    localparam logic [CSR_ADDR_W-1:0] ADDR_MINSTRET  = CSR_ADDR_W'('hB02);
    localparam logic [CSR_ADDR_W-1:0] ADDR_MINSTRETH = CSR_ADDR_W'('hB82);
    localparam logic [CSR_ADDR_W-1:0] ADDR_CYCLE     = CSR_ADDR_W'('hC00);
    localparam logic [CSR_ADDR_W-1:0] ADDR_CYCLEH    = CSR_ADDR_W'('hC80);
    localparam logic [CSR_ADDR_W-1:0] ADDR_INSTRET   = CSR_ADDR_W'('hC02);
    localparam logic [CSR_ADDR_W-1:0] ADDR_INSTRETH  = CSR_ADDR_W'('hC82);

    // Word-aligned registers (mtvec, mepc) never hold bits [1:0].
    localparam logic [WORD_SIZE-1:0] ALIGN_MASK = {{(WORD_SIZE-2){1'b1}}, 2'b00};
    // mie keeps only the software, timer and external enable bits.
    localparam logic [WORD_SIZE-1:0] MIE_MASK   = WORD_SIZE'('h888);

    // Architectural state.
    logic                 mstatus_mie_q;
    logic                 mstatus_mpie_q;
    logic [WORD_SIZE-1:0] mie_q;
    logic [WORD_SIZE-1:0] mtvec_q;
    logic [WORD_SIZE-1:0] mscratch_q;
    logic [WORD_SIZE-1:0] mepc_q;
    logic [WORD_SIZE-1:0] mcause_q;
    logic [WORD_SIZE-1:0] mtval_q;
    logic [CNT_W-1:0]     mcycle_q;
    logic [CNT_W-1:0]     mcycle_d;
    logic [CNT_W-1:0]     minstret_q;
    logic [CNT_W-1:0]     minstret_d;

    // Request decode.
    logic [WORD_SIZE-1:0] mstatus_rd;
    logic [WORD_SIZE-1:0] rdata;
    logic                 mapped;
    logic                 shadow;
    logic                 write_attempt;
    logic                 illegal;
    logic                 csr_we;
    logic [WORD_SIZE-1:0] wval;

    logic we_mstatus;
    logic we_mie;
    logic we_mtvec;
    logic we_mscratch;
    logic we_mepc;
    logic we_mcause;
    logic we_mtval;
    logic we_mcycle;
    logic we_mcycleh;
    logic we_minstret;
    logic we_minstreth;

    // Assemble the visible mstatus: MPP is hardwired to machine mode.
    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mstatus_mpie_q;
        mstatus_rd[3]     = mstatus_mie_q;
    end

    // Read mux: also reports whether the address exists and whether it is a read-only shadow.
    always_comb begin
        rdata  = '0;
        mapped = 1'b0;
        shadow = 1'b0;
        case (bus.csr_addr_i)
            ADDR_MSTATUS:  begin mapped = 1'b1; rdata = mstatus_rd; end
            ADDR_MIE:      begin mapped = 1'b1; rdata = mie_q;      end
            ADDR_MTVEC:    begin mapped = 1'b1; rdata = mtvec_q;    end
            ADDR_MSCRATCH: begin mapped = 1'b1; rdata = mscratch_q; end
            ADDR_MEPC:     begin mapped = 1'b1; rdata = mepc_q;     end
            ADDR_MCAUSE:   begin mapped = 1'b1; rdata = mcause_q;   end
            ADDR_MTVAL:    begin mapped = 1'b1; rdata = mtval_q;    end
            ADDR_MCYCLE, ADDR_CYCLE: begin
                if (HAS_COUNTERS) begin
                    mapped = 1'b1;
                    rdata  = mcycle_q[WORD_SIZE-1:0];
                end
            end
            ADDR_MCYCLEH, ADDR_CYCLEH: begin
                if (HAS_COUNTERS) begin
                    mapped = 1'b1;
                    rdata  = mcycle_q[CNT_W-1:WORD_SIZE];
                end
            end
            ADDR_MINSTRET, ADDR_INSTRET: begin
                if (HAS_COUNTERS) begin
                    mapped = 1'b1;
                    rdata  = minstret_q[WORD_SIZE-1:0];
                end
            end
            ADDR_MINSTRETH, ADDR_INSTRETH: begin
                if (HAS_COUNTERS) begin
                    mapped = 1'b1;
                    rdata  = minstret_q[CNT_W-1:WORD_SIZE];
                end
            end
            default: begin
                mapped = 1'b0;
            end
        endcase
        shadow = (bus.csr_addr_i == ADDR_CYCLE)   || (bus.csr_addr_i == ADDR_CYCLEH) ||
                 (bus.csr_addr_i == ADDR_INSTRET) || (bus.csr_addr_i == ADDR_INSTRETH);
    end

    // RS/RC with a zero operand are pure reads, so they are allowed on the shadows.
    assign write_attempt = (bus.csr_op_i == OP_RW) ||
                           (((bus.csr_op_i == OP_RS) || (bus.csr_op_i == OP_RC)) &&
                            (bus.csr_wdata_i != '0));
    assign illegal = (bus.csr_op_i != OP_NONE) && (!mapped || (shadow && write_attempt));
    // Trap entry and mret win over the CSR port; the losing write is simply dropped.
    assign csr_we  = write_attempt && !illegal && !bus.exc_i && !bus.mret_i;

    // Read-modify-write result, before the per-register write mask.
    always_comb begin
        wval = rdata;
        case (bus.csr_op_i)
            OP_RW:   wval = bus.csr_wdata_i;
            OP_RS:   wval = rdata | bus.csr_wdata_i;
            OP_RC:   wval = rdata & ~bus.csr_wdata_i;
            default: wval = rdata;
        endcase
    end

    assign we_mstatus   = csr_we && (bus.csr_addr_i == ADDR_MSTATUS);
    assign we_mie       = csr_we && (bus.csr_addr_i == ADDR_MIE);
    assign we_mtvec     = csr_we && (bus.csr_addr_i == ADDR_MTVEC);
    assign we_mscratch  = csr_we && (bus.csr_addr_i == ADDR_MSCRATCH);
    assign we_mepc      = csr_we && (bus.csr_addr_i == ADDR_MEPC);
    assign we_mcause    = csr_we && (bus.csr_addr_i == ADDR_MCAUSE);
    assign we_mtval     = csr_we && (bus.csr_addr_i == ADDR_MTVAL);
    assign we_mcycle    = csr_we && (bus.csr_addr_i == ADDR_MCYCLE);
    assign we_mcycleh   = csr_we && (bus.csr_addr_i == ADDR_MCYCLEH);
    assign we_minstret  = csr_we && (bus.csr_addr_i == ADDR_MINSTRET);
    assign we_minstreth = csr_we && (bus.csr_addr_i == ADDR_MINSTRETH);

    // Counter next state: a write to one half replaces it and skips that cycle's increment (no carry).
    always_comb begin
        mcycle_d   = mcycle_q + CNT_W'(1);
        minstret_d = minstret_q + CNT_W'(bus.retire_i);
        if (we_mcycle) begin
            mcycle_d = {mcycle_q[CNT_W-1:WORD_SIZE], wval};
        end else if (we_mcycleh) begin
            mcycle_d = {wval, mcycle_q[WORD_SIZE-1:0]};
        end
        if (we_minstret) begin
            minstret_d = {minstret_q[CNT_W-1:WORD_SIZE], wval};
        end else if (we_minstreth) begin
            minstret_d = {wval, minstret_q[WORD_SIZE-1:0]};
        end
        if (!HAS_COUNTERS) begin
            mcycle_d   = '0;
            minstret_d = '0;
        end
    end

    // State update: trap entry, then mret, then CSR-port writes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= MTVEC_RESET & ALIGN_MASK;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            if (bus.exc_i) begin
                mepc_q         <= bus.exc_pc_i & ALIGN_MASK;
                mcause_q       <= bus.exc_cause_i;
                mtval_q        <= bus.exc_tval_i;
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
            end else if (bus.mret_i) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
            end else begin
                if (we_mstatus) begin
                    mstatus_mie_q  <= wval[3];
                    mstatus_mpie_q <= wval[7];
                end
                if (we_mie) begin
                    mie_q <= wval & MIE_MASK;
                end
                if (we_mtvec) begin
                    mtvec_q <= wval & ALIGN_MASK;
                end
                if (we_mscratch) begin
                    mscratch_q <= wval;
                end
                if (we_mepc) begin
                    mepc_q <= wval & ALIGN_MASK;
                end
                if (we_mcause) begin
                    mcause_q <= wval;
                end
                if (we_mtval) begin
                    mtval_q <= wval;
                end
            end
        end
    end

    assign bus.csr_rdata_o   = rdata;
    assign bus.csr_illegal_o = illegal;
    assign bus.mtvec_o       = mtvec_q;
    assign bus.mepc_o        = mepc_q;
    assign bus.mie_global_o  = mstatus_mie_q;

endmodule

// File: tb/tb_segre_csr_unit.sv
// Directed bench for segre_csr_unit: vector table plus hand-written trap, counter and reset sequences.
module tb_segre_csr_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    segre_csr_if #(.WORD_SIZE(32), .CSR_ADDR_W(12)) bus_a ();
    segre_csr_if #(.WORD_SIZE(32), .CSR_ADDR_W(12)) bus_b ();

    segre_csr_unit #(
        .WORD_SIZE(32), .CSR_ADDR_W(12),
        .MTVEC_RESET(32'h8000_0103), .HAS_COUNTERS(1'b1)
    ) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a)
    );

    segre_csr_unit #(
        .WORD_SIZE(32), .CSR_ADDR_W(12),
        .MTVEC_RESET(32'h0000_0000), .HAS_COUNTERS(1'b0)
    ) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b)
    );

    typedef struct {
        logic [11:0] addr;
        logic [1:0]  op;
        logic [31:0] wdata;
        logic        retire;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                       input logic r, input logic e, input logic m);
        bus_a.csr_addr_i  = a;
        bus_a.csr_op_i    = op;
        bus_a.csr_wdata_i = wd;
        bus_a.retire_i    = r;
        bus_a.exc_i       = e;
        bus_a.mret_i      = m;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    // Read-only cycle: drive a read, check rdata at the negedge, step to the next cycle.
    task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] exp);
        drv(a, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        smp;
        chk(nm, bus_a.csr_rdata_o, exp);
        adv;
    endtask

    initial begin
        drv(12'h000, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        bus_a.exc_cause_i = '0;
        bus_a.exc_pc_i    = '0;
        bus_a.exc_tval_i  = '0;
        bus_b.csr_addr_i  = '0;
        bus_b.csr_op_i    = 2'b00;
        bus_b.csr_wdata_i = '0;
        bus_b.retire_i    = 1'b0;
        bus_b.exc_i       = 1'b0;
        bus_b.mret_i      = 1'b0;
        bus_b.exc_cause_i = '0;
        bus_b.exc_pc_i    = '0;
        bus_b.exc_tval_i  = '0;

        //                addr    op     wdata         ret  chk  exp_rd        ill
        vecs.push_back('{12'hB00, 2'b00, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{12'hB00, 2'b00, 32'h0,        1'b0, 1'b1, 32'h1,        1'b0});
        vecs.push_back('{12'h300, 2'b00, 32'h0,        1'b0, 1'b1, 32'h0000_1800, 1'b0});
        vecs.push_back('{12'h305, 2'b00, 32'h0,        1'b0, 1'b1, 32'h8000_0100, 1'b0});
        vecs.push_back('{12'h340, 2'b01, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{12'h340, 2'b10, 32'h0000_00F0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{12'h340, 2'b11, 32'hFFFF_0000, 1'b0, 1'b1, 32'hDEAD_BEFF, 1'b0});
        vecs.push_back('{12'h340, 2'b00, 32'h0,        1'b0, 1'b1, 32'h0000_BEFF, 1'b0});
        vecs.push_back('{12'h300, 2'b01, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_1800, 1'b0});
        vecs.push_back('{12'h300, 2'b00, 32'h0,        1'b0, 1'b1, 32'h0000_1888, 1'b0});
        vecs.push_back('{12'h304, 2'b01, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{12'h304, 2'b00, 32'h0,        1'b0, 1'b1, 32'h0000_0888, 1'b0});
        vecs.push_back('{12'h305, 2'b01, 32'h1234_5677, 1'b0, 1'b1, 32'h8000_0100, 1'b0});
        vecs.push_back('{12'h305, 2'b00, 32'h0,        1'b0, 1'b1, 32'h1234_5674, 1'b0});
        vecs.push_back('{12'h341, 2'b01, 32'h0000_00FF, 1'b0, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{12'h341, 2'b00, 32'h0,        1'b0, 1'b1, 32'h0000_00FC, 1'b0});
        vecs.push_back('{12'h342, 2'b01, 32'hA5A5_A5A5, 1'b0, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{12'h342, 2'b00, 32'h0,        1'b0, 1'b1, 32'hA5A5_A5A5, 1'b0});
        vecs.push_back('{12'h343, 2'b01, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{12'h343, 2'b11, 32'h0000_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{12'h343, 2'b00, 32'h0,        1'b0, 1'b1, 32'hFFFF_0000, 1'b0});
        vecs.push_back('{12'h7C0, 2'b01, 32'h1,        1'b0, 1'b1, 32'h0,        1'b1});
        vecs.push_back('{12'hC00, 2'b01, 32'h1234,     1'b0, 1'b0, 32'h0,        1'b1});
        vecs.push_back('{12'hC00, 2'b10, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0});
        vecs.push_back('{12'hC80, 2'b10, 32'h1,        1'b0, 1'b0, 32'h0,        1'b1});
        vecs.push_back('{12'hC02, 2'b11, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{12'hB00, 2'b01, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0});
        vecs.push_back('{12'hB00, 2'b00, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{12'hC00, 2'b00, 32'h0,        1'b0, 1'b1, 32'h1,        1'b0});
        vecs.push_back('{12'hB02, 2'b00, 32'h0,        1'b1, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{12'hC02, 2'b00, 32'h0,        1'b0, 1'b1, 32'h1,        1'b0});
        vecs.push_back('{12'hB02, 2'b01, 32'h5,        1'b1, 1'b1, 32'h1,        1'b0});
        vecs.push_back('{12'hB02, 2'b00, 32'h0,        1'b0, 1'b1, 32'h5,        1'b0});
        vecs.push_back('{12'hB82, 2'b01, 32'h7,        1'b0, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{12'hC82, 2'b00, 32'h0,        1'b0, 1'b1, 32'h7,        1'b0});
        vecs.push_back('{12'hB02, 2'b00, 32'h0,        1'b0, 1'b1, 32'h5,        1'b0});
        vecs.push_back('{12'h300, 2'b10, 32'h0,        1'b0, 1'b1, 32'h0000_1888, 1'b0});
        vecs.push_back('{12'h340, 2'b11, 32'h0,        1'b0, 1'b1, 32'h0000_BEFF, 1'b0});
        vecs.push_back('{12'h340, 2'b00, 32'h0,        1'b0, 1'b1, 32'h0000_BEFF, 1'b0});
        vecs.push_back('{12'hC82, 2'b01, 32'hFF,       1'b0, 1'b0, 32'h0,        1'b1});
        vecs.push_back('{12'hC82, 2'b00, 32'h0,        1'b0, 1'b1, 32'h7,        1'b0});

        // Reset state
        repeat (2) @(posedge clk);
        smp;
        chk("rst_mtvec_o", bus_a.mtvec_o, 32'h8000_0100);
        chk("rst_mepc_o", bus_a.mepc_o, 32'h0);
        chk("rst_mie_global_o", {31'h0, bus_a.mie_global_o}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            drv(vecs[i].addr, vecs[i].op, vecs[i].wdata, vecs[i].retire, 1'b0, 1'b0);
            smp;
            if (vecs[i].chk_rd)
                chk($sformatf("vec%0d_rdata", i), bus_a.csr_rdata_o, vecs[i].exp_rd);
            chk($sformatf("vec%0d_illegal", i), {31'h0, bus_a.csr_illegal_o}, {31'h0, vecs[i].exp_ill});
            adv;
        end

        // Trap entry then mret
        smp;
        chk("pre_trap_mie_global", {31'h0, bus_a.mie_global_o}, 32'h1);
        chk("pre_trap_mtvec_o", bus_a.mtvec_o, 32'h1234_5674);
        bus_a.exc_cause_i = 32'h2;
        bus_a.exc_pc_i    = 32'h0000_1236;
        bus_a.exc_tval_i  = 32'h0000_0BAD;
        drv(12'h300, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
        adv;
        drv(12'h342, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        smp;
        chk("trap_mepc_o", bus_a.mepc_o, 32'h0000_1234);
        chk("trap_mie_global", {31'h0, bus_a.mie_global_o}, 32'h0);
        chk("trap_mcause", bus_a.csr_rdata_o, 32'h2);
        adv;
        rd_chk("trap_mtval", 12'h343, 32'h0000_0BAD);
        rd_chk("trap_mstatus", 12'h300, 32'h0000_1880);
        drv(12'h300, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
        smp;
        chk("mret_pre_read", bus_a.csr_rdata_o, 32'h0000_1880);
        adv;
        drv(12'h300, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        smp;
        chk("mret_mstatus", bus_a.csr_rdata_o, 32'h0000_1888);
        chk("mret_mie_global", {31'h0, bus_a.mie_global_o}, 32'h1);
        adv;

        // exc + mret + RW mepc together: only the trap lands
        bus_a.exc_cause_i = 32'h8000_000B;
        bus_a.exc_pc_i    = 32'h4000_0002;
        drv(12'h341, 2'b01, 32'h5555_0000, 1'b0, 1'b1, 1'b1);
        smp;
        chk("collide_old_mepc", bus_a.csr_rdata_o, 32'h0000_1234);
        adv;
        rd_chk("collide_mepc", 12'h341, 32'h4000_0000);
        rd_chk("collide_mstatus", 12'h300, 32'h0000_1880);
        rd_chk("collide_mcause", 12'h342, 32'h8000_000B);
        // mret beats a CSR write
        drv(12'h340, 2'b01, 32'h1111_1111, 1'b0, 1'b0, 1'b1);
        adv;
        rd_chk("mret_drop_mscratch", 12'h340, 32'h0000_BEFF);
        rd_chk("mret_drop_mstatus", 12'h300, 32'h0000_1888);

        // mcycle low overflow carries into mcycleh
        rd_chk("cyc_h_before", 12'hB80, 32'h0);
        drv(12'hB00, 2'b01, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        adv;
        rd_chk("cyc_lo_written", 12'hB00, 32'hFFFF_FFFF);
        rd_chk("cyc_h_carry", 12'hC80, 32'h1);
        rd_chk("cyc_lo_after", 12'hB00, 32'h1);
        // full 64-bit wrap
        drv(12'hB00, 2'b01, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        adv;
        drv(12'hB80, 2'b01, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        smp;
        chk("wrap_old_h", bus_a.csr_rdata_o, 32'h1);
        adv;
        rd_chk("wrap_h_ones", 12'hB80, 32'hFFFF_FFFF);
        rd_chk("wrap_lo_zero", 12'hB00, 32'h0);
        rd_chk("wrap_h_zero", 12'hB80, 32'h0);

        // Counterless instance: every counter address is illegal, ordinary CSRs are not
        for (int i = 0; i < 5; i++) begin
            logic [11:0] a;
            logic [31:0] ill_exp;
            case (i)
                0: a = 12'hB00;
                1: a = 12'hC00;
                2: a = 12'hB82;
                3: a = 12'hC82;
                default: a = 12'h340;
            endcase
            ill_exp = (i == 4) ? 32'h0 : 32'h1;
            bus_b.csr_addr_i  = a;
            bus_b.csr_op_i    = 2'b10;
            bus_b.csr_wdata_i = 32'h0;
            smp;
            chk($sformatf("nocnt_ill_%h", a), {31'h0, bus_b.csr_illegal_o}, ill_exp);
            adv;
        end
        bus_b.csr_op_i = 2'b00;

        // Reset in the middle of a write
        drv(12'h340, 2'b01, 32'hCAFE_0000, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_mtvec_o", bus_a.mtvec_o, 32'h8000_0100);
        chk("midrst_mepc_o", bus_a.mepc_o, 32'h0);
        chk("midrst_mie_global", {31'h0, bus_a.mie_global_o}, 32'h0);
        drv(12'hB00, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        smp;
        chk("postrst_cycle0", bus_a.csr_rdata_o, 32'h0);
        adv;
        smp;
        chk("postrst_cycle1", bus_a.csr_rdata_o, 32'h1);
        adv;
        rd_chk("postrst_mscratch", 12'h340, 32'h0);
        rd_chk("postrst_mstatus", 12'h300, 32'h0000_1800);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
